// File: rtl/riscv_core_mc.sv
// riscv_core_mc: multi-cycle RV32I core on req/ack instruction/data buses.
// Define RISCV_PERF_CNT_EN to add the cycle_cnt/instret_cnt counter ports.
module riscv_core_mc #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16,
  parameter int          CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] instruction,
  output logic        halted,
  output logic [2:0]  halt_cause
`ifdef RISCV_PERF_CNT_EN
  ,
  output logic [63:0] cycle_cnt,
  output logic [63:0] instret_cnt
`endif
);

  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_DEC   = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_HALT  = 3'd5;

  localparam logic [CNT_WIDTH-1:0] LP_TO =
    CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CNT_WIDTH-1:0] LP_ONE =
    {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]  r_state;
  logic [31:0] r_pc, r_ir, r_a, r_b, r_imm;
  logic [31:0] r_alu, r_tgt, r_mdr;
  logic        r_taken;
  logic [2:0]  r_cause;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [31:0] r_rf [32];

  logic [6:0]  w_op;
  logic [2:0]  w_f3;
  logic [4:0]  w_rd, w_rs1, w_rs2;
  logic        w_lui, w_auipc, w_jal, w_jalr, w_br;
  logic        w_ld, w_st, w_opi, w_opr, w_fence;
  logic        w_sys, w_ecall, w_illegal;
  logic [31:0] w_imm, w_rs1d, w_rs2d;
  logic [31:0] w_opa, w_opb, w_alu, w_jtgt;
  logic [3:0]  w_sel;
  logic        w_cond, w_fmis, w_mis, w_to, w_rfwe;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [3:0]  w_be;
  logic [31:0] w_sdata, w_ldsh, w_ldv, w_wbd;

  assign w_op  = r_ir[6:0];
  assign w_f3  = r_ir[14:12];
  assign w_rd  = r_ir[11:7];
  assign w_rs1 = r_ir[19:15];
  assign w_rs2 = r_ir[24:20];

  assign w_lui   = w_op == 7'b0110111;
  assign w_auipc = w_op == 7'b0010111;
  assign w_jal   = w_op == 7'b1101111;
  assign w_jalr  = w_op == 7'b1100111;
  assign w_br    = w_op == 7'b1100011;
  assign w_ld    = w_op == 7'b0000011;
  assign w_st    = w_op == 7'b0100011;
  assign w_opi   = w_op == 7'b0010011;
  assign w_opr   = w_op == 7'b0110011;
  assign w_fence = w_op == 7'b0001111;
  assign w_sys   = w_op == 7'b1110011;
  assign w_ecall = w_sys && (w_f3 == 3'd0);
  assign w_illegal = !(w_lui | w_auipc | w_jal | w_jalr |
    w_br | w_ld | w_st | w_opi | w_opr | w_fence | w_ecall);

  always_comb begin
    w_imm = {{20{r_ir[31]}}, r_ir[31:20]};
    unique case (1'b1)
      w_st: w_imm = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
      w_br: w_imm = {{19{r_ir[31]}}, r_ir[31], r_ir[7],
                     r_ir[30:25], r_ir[11:8], 1'b0};
      w_lui, w_auipc: w_imm = {r_ir[31:12], 12'b0};
      w_jal: w_imm = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12],
                      r_ir[20], r_ir[30:21], 1'b0};
      default: ;
    endcase
  end

  assign w_rs1d = (w_rs1 == 5'd0) ? 32'd0 : r_rf[w_rs1];
  assign w_rs2d = (w_rs2 == 5'd0) ? 32'd0 : r_rf[w_rs2];

  always_comb begin
    w_opa = r_a;
    w_opb = r_imm;
    w_sel = 4'b0000;
    unique case (1'b1)
      w_lui:   w_opa = 32'd0;
      w_auipc: w_opa = r_pc;
      w_opr: begin
        w_opb = r_b;
        w_sel = {r_ir[30], w_f3};
      end
      // bit 30 is immediate data for all OP-IMM except SRAI
      w_opi: w_sel = {r_ir[30] & (w_f3 == 3'b101), w_f3};
      default: ;
    endcase
  end

  always_comb begin
    unique case (w_sel[2:0])
      3'b000: w_alu = w_sel[3] ? w_opa - w_opb : w_opa + w_opb;
      3'b001: w_alu = w_opa << w_opb[4:0];
      3'b010: w_alu = {31'd0, $signed(w_opa) < $signed(w_opb)};
      3'b011: w_alu = {31'd0, w_opa < w_opb};
      3'b100: w_alu = w_opa ^ w_opb;
      3'b101: w_alu = w_sel[3] ?
        32'($signed(w_opa) >>> w_opb[4:0]) : w_opa >> w_opb[4:0];
      3'b110: w_alu = w_opa | w_opb;
      default: w_alu = w_opa & w_opb;
    endcase
  end

  always_comb begin
    unique case (w_f3)
      3'b000: w_cond = r_a == r_b;
      3'b001: w_cond = r_a != r_b;
      3'b100: w_cond = $signed(r_a) < $signed(r_b);
      3'b101: w_cond = $signed(r_a) >= $signed(r_b);
      3'b110: w_cond = r_a < r_b;
      3'b111: w_cond = r_a >= r_b;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_jtgt = w_jalr ? ((r_a + r_imm) & 32'hFFFF_FFFE)
                         : r_pc + r_imm;

  assign w_fmis = |r_pc[1:0];
  assign w_mis  = w_f3[1] ? |r_alu[1:0] : (w_f3[0] & r_alu[0]);
  assign w_cnt_inc = r_cnt + LP_ONE;
  assign w_to = (TIMEOUT_CYCLES != 0) && (w_cnt_inc == LP_TO);

  always_comb begin
    w_be    = 4'b1111;
    w_sdata = r_b;
    if (!w_f3[1]) begin
      w_be    = (w_f3[0] ? 4'b0011 : 4'b0001) << r_alu[1:0];
      w_sdata = w_f3[0] ? {2{r_b[15:0]}} : {4{r_b[7:0]}};
    end
  end

  assign w_ldsh = r_mdr >> {r_alu[1:0], 3'b000};

  always_comb begin
    unique case (w_f3[1:0])
      2'b00: w_ldv = {{24{~w_f3[2] & w_ldsh[7]}}, w_ldsh[7:0]};
      2'b01: w_ldv = {{16{~w_f3[2] & w_ldsh[15]}}, w_ldsh[15:0]};
      default: w_ldv = r_mdr;
    endcase
  end

  assign w_wbd = (w_jal | w_jalr) ? r_pc + 32'd4 :
                 w_ld ? w_ldv : r_alu;
  assign w_rfwe = rst_n && (r_state == S_WB) && (w_rd != 5'd0) &&
    (w_lui | w_auipc | w_jal | w_jalr | w_ld | w_opi | w_opr);

  always_ff @(posedge clk) begin
    if (w_rfwe) r_rf[w_rd] <= w_wbd;
  end

  assign imem_req   = rst_n && (r_state == S_FETCH) && !w_fmis;
  assign imem_addr  = r_pc;
  assign dmem_req   = rst_n && (r_state == S_MEM) && !w_mis;
  assign dmem_we    = dmem_req && w_st;
  assign dmem_addr  = {r_alu[31:2], 2'b00};
  assign dmem_be    = dmem_req ? w_be : 4'b0000;
  assign dmem_wdata = dmem_req ? w_sdata : 32'd0;
  assign instruction = r_ir;
  assign halted      = r_state == S_HALT;
  assign halt_cause  = r_cause;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_pc    <= RESET_PC;
      r_ir    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_imm   <= '0;
      r_alu   <= '0;
      r_tgt   <= '0;
      r_mdr   <= '0;
      r_taken <= 1'b0;
      r_cause <= 3'd0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_fmis) begin
            r_state <= S_HALT;
            r_cause <= 3'd2;
          end else if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DEC;
          end else if (w_to) begin
            r_state <= S_HALT;
            r_cause <= 3'd4;
          end else r_cnt <= w_cnt_inc;
        end
        S_DEC: begin
          r_a   <= w_rs1d;
          r_b   <= w_rs2d;
          r_imm <= w_imm;
          if (w_illegal) begin
            r_state <= S_HALT;
            r_cause <= 3'd1;
          end else if (w_ecall) begin
            r_state <= S_HALT;
            r_cause <= 3'd6;
          end else r_state <= S_EXEC;
        end
        S_EXEC: begin
          r_alu   <= w_alu;
          r_tgt   <= w_jtgt;
          r_taken <= w_jal | w_jalr | (w_br & w_cond);
          r_cnt   <= '0;
          r_state <= (w_ld | w_st) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (w_mis) begin
            r_state <= S_HALT;
            r_cause <= 3'd3;
          end else if (dmem_ack) begin
            r_mdr   <= dmem_rdata;
            r_state <= S_WB;
          end else if (w_to) begin
            r_state <= S_HALT;
            r_cause <= 3'd5;
          end else r_cnt <= w_cnt_inc;
        end
        S_WB: begin
          r_pc    <= r_taken ? r_tgt : r_pc + 32'd4;
          r_cnt   <= '0;
          r_state <= S_FETCH;
        end
        default: r_state <= S_HALT;
      endcase
    end
  end

`ifdef RISCV_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (r_state != S_HALT) cycle_cnt <= cycle_cnt + 64'd1;
      if (r_state == S_WB) instret_cnt <= instret_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_mc.sv
// tb_riscv_core_mc: directed scoreboard bench for riscv_core_mc.
// Memories are behavioural with programmable ack wait states.
module tb_riscv_core_mc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic [31:0] instruction;
  logic        halted;
  logic [2:0]  halt_cause;
`ifdef RISCV_PERF_CNT_EN
  logic [63:0] cycle_cnt, instret_cnt;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } st_t;

  st_t exp_q[$];
  st_t obs_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_dreq = 0;
  int n_imis = 0;
  int iwait = 0;
  int dwait = 0;
  int icnt = 0;
  int dcnt = 0;
  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  always #5 clk = ~clk;

  riscv_core_mc #(
    .RESET_PC(32'h0), .TIMEOUT_CYCLES(16), .CNT_WIDTH(5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .instruction(instruction),
    .halted(halted), .halt_cause(halt_cause)
`ifdef RISCV_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  always_comb begin
    imem_ack   = imem_req && (icnt >= iwait);
    imem_rdata = imem[imem_addr[7:2]];
    dmem_ack   = dmem_req && (dcnt >= dwait);
    dmem_rdata = dmem[dmem_addr[7:2]];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt <= 0;
      dcnt <= 0;
    end else begin
      icnt <= (imem_req && !imem_ack) ? icnt + 1 : 0;
      dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;
    end
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_ack && dmem_we)
      for (int b = 0; b < 4; b++)
        if (dmem_be[b])
          dmem[dmem_addr[7:2]][8*b +: 8] <= dmem_wdata[8*b +: 8];
  end

  always @(negedge clk) begin
    if (dmem_req) n_dreq <= n_dreq + 1;
    if (imem_req && imem_addr[1:0] != 2'b00) n_imis <= n_imis + 1;
    if (dmem_req && dmem_ack && dmem_we)
      obs_q.push_back('{dmem_addr, dmem_be, dmem_wdata});
  end

  function automatic logic [31:0] enc_i(input int imm, rs1, f3, rd,
                                        input logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0],
            7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0],
            imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0],
            7'b1101111};
  endfunction

  function automatic logic [31:0] enc_r(input int f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0],
            7'b0110011};
  endfunction

  function automatic logic [31:0] addi(input int rd, rs1, imm);
    return enc_i(imm, rs1, 0, rd, 7'b0010011);
  endfunction

  function automatic logic [31:0] load(input int f3, rd, rs1, imm);
    return enc_i(imm, rs1, f3, rd, 7'b0000011);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] req);
    n_chk++;
    assert (obs === req) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, req);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 64; i++) imem[i] = EBREAK;
    exp_q.delete();
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    exp_q.push_back('{a, be, d});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    obs_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_halt(input string tag, input int max);
    int n;
    n = 0;
    while (!halted && n < max) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk({tag, "_halted"}, 32'(halted), 32'd1);
  endtask

  task automatic drain(input string tag);
    st_t e, o;
    chk({tag, "_nstores"}, 32'(obs_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk($sformatf("%s_addr_%0h", tag, e.addr), o.addr, e.addr);
      chk($sformatf("%s_be_%0h", tag, e.addr), 32'(o.be), 32'(e.be));
      chk($sformatf("%s_data_%0h", tag, e.addr), o.data, e.data);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int n;

    // Program A: ALU, sub-word load/store, branch, jump, EBREAK
    clear_prog();
    imem[0]  = addi(1, 0, 5);
    imem[1]  = addi(2, 1, -7);
    imem[2]  = enc_s(16, 1, 0, 2);
    imem[3]  = enc_s(20, 2, 0, 2);
    imem[4]  = addi(5, 0, 165);
    imem[5]  = enc_s(3, 5, 0, 0);
    imem[6]  = load(0, 3, 0, 3);
    imem[7]  = enc_s(24, 3, 0, 2);
    imem[8]  = load(4, 4, 0, 3);
    imem[9]  = enc_s(28, 4, 0, 2);
    imem[10] = addi(6, 0, -2);
    imem[11] = enc_s(6, 6, 0, 1);
    imem[12] = load(1, 7, 0, 6);
    imem[13] = enc_s(32, 7, 0, 2);
    imem[14] = load(5, 8, 0, 6);
    imem[15] = enc_s(36, 8, 0, 2);
    imem[16] = addi(9, 0, 7);
    imem[17] = enc_b(8, 1, 1, 0);
    imem[18] = addi(9, 0, 1);
    imem[19] = enc_s(40, 9, 0, 2);
    imem[20] = enc_j(8, 10);
    imem[21] = addi(9, 0, 2);
    imem[22] = enc_s(44, 10, 0, 2);
    imem[23] = enc_r(32, 1, 2, 0, 11);
    imem[24] = enc_s(48, 11, 0, 2);
    push_exp(32'd16, 4'b1111, 32'd5);
    push_exp(32'd20, 4'b1111, 32'hFFFF_FFFE);
    push_exp(32'd0,  4'b1000, 32'hA5A5_A5A5);
    push_exp(32'd24, 4'b1111, 32'hFFFF_FFA5);
    push_exp(32'd28, 4'b1111, 32'h0000_00A5);
    push_exp(32'd4,  4'b1100, 32'hFFFE_FFFE);
    push_exp(32'd32, 4'b1111, 32'hFFFF_FFFE);
    push_exp(32'd36, 4'b1111, 32'h0000_FFFE);
    push_exp(32'd40, 4'b1111, 32'd7);
    push_exp(32'd44, 4'b1111, 32'd84);
    push_exp(32'd48, 4'b1111, 32'hFFFF_FFF9);

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_dmem_req", 32'(dmem_req), 32'd0);
    chk("rst_dmem_be", 32'(dmem_be), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_cause", 32'(halt_cause), 32'd0);
    chk("rst_ir", instruction, 32'd0);
    obs_q.delete();
    rst_n = 1'b1;
    #1 chk("rst_pc", imem_addr, 32'd0);
    repeat (7) @(posedge clk);
    #1 chk("a_pc_7cyc", imem_addr, 32'd4);
    @(posedge clk);
    #1 chk("a_pc_8cyc", imem_addr, 32'd8);
    chk("a_ir_addi2", instruction, addi(2, 1, -7));
    wait_halt("a", 400);
    chk("a_cause", 32'(halt_cause), 32'd6);
    chk("a_halt_pc", imem_addr, 32'd100);
    drain("a");

    // imem ack three cycles late on every fetch
    clear_prog();
    imem[0] = addi(1, 0, 9);
    imem[1] = enc_s(52, 1, 0, 2);
    push_exp(32'd52, 4'b1111, 32'd9);
    iwait = 3;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b_ir_wait%0d", i), instruction, 32'd0);
      chk($sformatf("b_pc_wait%0d", i), imem_addr, 32'd0);
      chk($sformatf("b_req_wait%0d", i), 32'(imem_req), 32'd1);
    end
    repeat (3) @(posedge clk);
    #1 chk("b_pc_6cyc", imem_addr, 32'd0);
    @(posedge clk);
    #1 chk("b_pc_7cyc", imem_addr, 32'd4);
    wait_halt("b", 200);
    chk("b_cause", 32'(halt_cause), 32'd6);
    drain("b");
    iwait = 0;

    // dmem never acks: timeout after 16 request cycles
    clear_prog();
    imem[0] = enc_s(0, 0, 0, 2);
    dwait = 1000;
    do_reset();
    #1 d0 = n_dreq;
    wait_halt("c", 100);
    chk("c_cause", 32'(halt_cause), 32'd5);
    chk("c_req_cycles", 32'(n_dreq - d0), 32'd16);
    repeat (5) @(negedge clk);
    #1;
    chk("c_no_req_after", 32'(n_dreq - d0), 32'd16);
    chk("c_no_fetch", 32'(imem_req), 32'd0);
    dwait = 0;

    // misaligned LW: no data request
    clear_prog();
    imem[0] = load(2, 4, 0, 2);
    do_reset();
    #1 d0 = n_dreq;
    wait_halt("d", 50);
    chk("d_cause", 32'(halt_cause), 32'd3);
    chk("d_no_dreq", 32'(n_dreq - d0), 32'd0);
    chk("d_pc", imem_addr, 32'd0);

    // unsupported opcode
    clear_prog();
    imem[0] = 32'h0000_007F;
    do_reset();
    wait_halt("e", 50);
    chk("e_cause", 32'(halt_cause), 32'd1);
    chk("e_pc", imem_addr, 32'd0);

    // JALR to pc 2: misaligned fetch, no request
    clear_prog();
    imem[0] = enc_i(2, 0, 0, 0, 7'b1100111);
    do_reset();
    #1 d0 = n_imis;
    wait_halt("f", 50);
    chk("f_cause", 32'(halt_cause), 32'd2);
    chk("f_pc", imem_addr, 32'd2);
    chk("f_no_ireq", 32'(n_imis - d0), 32'd0);

    // reset mid-MEM, registers survive
    clear_prog();
    imem[0] = addi(1, 0, 51);
    imem[1] = enc_s(0, 1, 0, 2);
    dwait = 1000;
    do_reset();
    n = 0;
    while (!dmem_req && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("g_in_mem", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("g_req_drop", 32'(dmem_req), 32'd0);
    chk("g_ireq_rst", 32'(imem_req), 32'd0);
    imem[0] = enc_s(4, 1, 0, 2);
    imem[1] = EBREAK;
    push_exp(32'd4, 4'b1111, 32'd51);
    dwait = 0;
    @(negedge clk);
    obs_q.delete();
    rst_n = 1'b1;
    #1;
    chk("g_pc_restart", imem_addr, 32'd0);
    chk("g_fetch_restart", 32'(imem_req), 32'd1);
    wait_halt("g", 50);
    chk("g_cause", 32'(halt_cause), 32'd6);
    drain("g");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
